// File: rtl/uart_pkg.sv
// Shared UART constants: FSM encoding, frame shape and default baud divisor.
// Used by both the transmit and receive paths; no logic, no latency.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_START = START,
    ST_DATA  = DATA,
    ST_STOP  = STOP
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // 100 MHz sysclk / 9600 baud, rounded.
  localparam int UART_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the CPU peripheral logic (master) and the UART transmitter (slave).
// Valid/ready: a byte moves on any rising edge with tx_valid && tx_ready.
interface uart_tx_if;

  logic [uart_pkg::UART_DATA_BITS-1:0] tx_data;
  logic                                tx_valid;
  logic                                tx_ready;
  logic                                tx_busy;
  logic                                tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, bit_end high while at the last count.
// clr restarts the period on the next edge; wraps by itself at each bit boundary.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: frame of 10*CLKS_PER_BIT cycles, line falls on the handshake edge.
// Accepts a byte only in IDLE; tx_valid outside IDLE is ignored, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic     sysclk,
  input  logic     reset,
  uart_tx_if.slave tx_if,
  output logic     UART_TX
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state;
  logic [UART_DATA_BITS-1:0] shift;
  logic [2:0]                bit_idx;
  logic                      done_q;
  logic                      handshake;
  logic                      bit_end;

  assign handshake      = tx_if.tx_valid && (state == ST_IDLE);
  assign tx_if.tx_ready = (state == ST_IDLE);
  assign tx_if.tx_busy  = (state != ST_IDLE);
  assign tx_if.tx_done  = done_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .sysclk  (sysclk),
    .reset   (reset),
    .clr     (handshake),
    .bit_end (bit_end)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      UART_TX <= 1'b1;
      done_q  <= 1'b0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_if.tx_valid) begin
            shift   <= tx_if.tx_data;
            bit_idx <= '0;
            UART_TX <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            UART_TX <= shift[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              UART_TX <= 1'b1;
              state   <= ST_STOP;
            end else begin
              // shift[1] is the bit that becomes shift[0] after this shift
              shift   <= shift >> 1;
              UART_TX <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

8N1 UART transmitter for the CPU's serial peripheral: the outbound counterpart of the UART receive path that drives `UART_TX`. The CPU's peripheral logic hands it one byte per valid/ready handshake. It serialises the byte as 1 start bit, 8 data bits (LSB first) and 1 stop bit, with a fixed number of clocks per bit. The line idles high.

## Interface
- `CLKS_PER_BIT`, default 10417: sysclk cycles per bit (100 MHz / 9600 baud, rounded); legal range ≥ 2.
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; sampled only on handshake.
- `tx_valid`  in  1  producer has a byte.
- `tx_ready`  out  1  block can accept a byte; high only in IDLE.
- `tx_busy`  out  1  frame in progress; equals !tx_ready.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.
- `UART_TX`  out  1  serial line; registered output, idles 1.

## Operation
- States: IDLE, START, DATA, STOP.
- Reset values while `reset`=0, asynchronous: state=IDLE, `UART_TX`=1, `tx_done`=0, bit counter=0, baud counter=0, shift register=0.
- IDLE: `tx_ready`=1. When `tx_valid`=1 on a rising edge, latch `tx_data` into the shift register, go to START and drive `UART_TX`=0.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with `UART_TX`=shift[0].
- DATA: each bit lasts CLKS_PER_BIT cycles. At each bit boundary, shift right and output the next bit. After bit 7, go to STOP with `UART_TX`=1.
- STOP: hold 1 for CLKS_PER_BIT cycles, then go to IDLE and assert `tx_done` for exactly one cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1. It resets to 0 on handshake and at every bit boundary. Width is $clog2(CLKS_PER_BIT).
- Bit index: 3 bits, 0..7. It does not wrap into a 9th data bit.
- `tx_data` and `tx_valid` are ignored outside IDLE. A `tx_valid` that arrives mid-frame is not queued; the producer must hold it until `tx_ready`.
- Reset mid-frame aborts the frame immediately. The line returns high, and no `tx_done` is generated for the aborted byte.

## Timing
- Handshake edge k, i.e. the first edge with `tx_valid` && `tx_ready`:
  - `UART_TX` falls at edge k.
  - Data bit i occupies edges k+(1+i)·N to k+(2+i)·N-1, where N=CLKS_PER_BIT.
  - The stop bit starts at edge k+9N.
  - State returns to IDLE at edge k+10N.
  - `tx_done`=1 during the cycle after edge k+10N.
- Frame length is 10·N cycles. If `tx_valid` is held, the next handshake occurs at edge k+10N+1, so back-to-back frames have an effective stop bit of N+1 cycles.
- `tx_ready` and `tx_busy` are decoded from registered state with no combinational path from `tx_valid`.
- `UART_TX` comes straight from a flop and must be glitch-free.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding: 2-bit localparams IDLE/START/DATA/STOP;
  - UART_DATA_BITS=8 and UART_STOP_BITS=1;
  - the default baud constant, shared with the receiver.
- One sub-module is natural: `uart_baud_cnt`.
  - Parameter CLKS_PER_BIT; inputs `sysclk`, `reset`, `clr`.
  - Output `bit_end` pulses when the count reaches CLKS_PER_BIT-1.
  - The receiver reuses it.
- Everything else (FSM, shift register, bit index) stays in `uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset: hold `reset`=0 for 3 cycles -> `UART_TX`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; release -> line stays 1 with no activity.
- Single byte: send 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; `tx_done` pulses once, 40 cycles after the handshake edge; the bench's UART sampler decodes 0xA5.
- Back-to-back: hold `tx_valid`=1 with 0x00 then 0xFF -> second start bit begins exactly 41 cycles after the first; both bytes decode; exactly 2 `tx_done` pulses.
- Ignored input: pulse `tx_valid` with 0x3C at cycle 10 of a 0x55 frame -> frame still carries 0x55, `tx_ready` stays 0 until IDLE, no extra frame follows.
- Reset mid-frame: assert `reset` during data bit 3 -> `UART_TX`=1 asynchronously, no `tx_done`; a new byte 0x81 after release transmits correctly.
- Boundary: CLKS_PER_BIT=2 with byte 0x01 -> 20-cycle frame and correct LSB-first order.
